// File: rtl/coin_conditioner_if.sv
// Coin mechanism <-> conditioner signal bundle: raw sensor lines and busy in,
// validated single-cycle event pulses and the stuck flag out.
interface coin_conditioner_if;
  logic raw_10p;
  logic raw_20p;
  logic raw_50p;
  logic raw_refund;
  logic busy;
  logic coin10p;
  logic coin20p;
  logic coin50p;
  logic refund;
  logic reject;
  logic err_stuck;

  modport master (
    output raw_10p, raw_20p, raw_50p, raw_refund, busy,
    input  coin10p, coin20p, coin50p, refund, reject, err_stuck
  );

  modport slave (
    input  raw_10p, raw_20p, raw_50p, raw_refund, busy,
    output coin10p, coin20p, coin50p, refund, reject, err_stuck
  );
endinterface

// File: rtl/coin_conditioner.sv
// Synchronises and debounces the coin/refund lines, emitting one registered
// pulse per validated insertion, rejecting ambiguous coins and flagging stuck sensors.
module coin_conditioner #(
  parameter int DB_CYCLES    = 4,
  parameter int STUCK_CYCLES = 64,
  parameter int CNT_W        = 7
) (
  input logic clk,
  input logic rst,
  coin_conditioner_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, PULSE, WAIT_RELEASE, STUCK} state_t;

  localparam logic [CNT_W-1:0] DB_C    = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             low_q, low_d;
  logic [3:0]       pulse_q, pulse_d;
  logic             reject_q, reject_d;
  logic             err_q, err_d;
  logic             one_hot;

  assign raw     = {bus.raw_refund, bus.raw_50p, bus.raw_20p, bus.raw_10p};
  assign one_hot = (sync2_q != 4'd0) && ((sync2_q & (sync2_q - 4'd1)) == 4'd0);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    low_d    = low_q;
    pulse_d  = 4'd0;
    reject_d = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          sel_d   = sync2_q;
          cnt_d   = ONE_C;
          state_d = DEBOUNCE;
        end else if (sync2_q != 4'd0) begin
          reject_d = |sync2_q[2:0];
          cnt_d    = '0;
          low_d    = 1'b0;
          state_d  = WAIT_RELEASE;
        end
      end
      DEBOUNCE: begin
        if (sync2_q != sel_q) begin
          state_d = IDLE;
        end else if (cnt_q < DB_C) begin
          cnt_d = cnt_q + ONE_C;
        end else if (bus.busy) begin
          // A refund press while busy is simply dropped; coins go to the chute.
          reject_d = |sel_q[2:0];
          cnt_d    = '0;
          low_d    = 1'b0;
          state_d  = WAIT_RELEASE;
        end else begin
          pulse_d = sel_q;
          state_d = PULSE;
        end
      end
      PULSE: begin
        cnt_d   = '0;
        low_d   = 1'b0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // low_q selects whether cnt is counting consecutive highs or lows.
        if (sync2_q != 4'd0) begin
          cnt_d = low_q ? ONE_C : cnt_q + ONE_C;
          low_d = 1'b0;
          if (cnt_d == STUCK_C) begin
            err_d   = 1'b1;
            state_d = STUCK;
          end
        end else begin
          cnt_d = low_q ? cnt_q + ONE_C : ONE_C;
          low_d = 1'b1;
          if (cnt_d == DB_C) state_d = IDLE;
        end
      end
      STUCK: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 4'd0;
      sync2_q  <= 4'd0;
      state_q  <= WAIT_RELEASE;
      sel_q    <= 4'd0;
      cnt_q    <= '0;
      low_q    <= 1'b0;
      pulse_q  <= 4'd0;
      reject_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      low_q    <= low_d;
      pulse_q  <= pulse_d;
      reject_q <= reject_d;
      err_q    <= err_d;
    end
  end

  assign bus.coin10p   = pulse_q[0];
  assign bus.coin20p   = pulse_q[1];
  assign bus.coin50p   = pulse_q[2];
  assign bus.refund    = pulse_q[3];
  assign bus.reject    = reject_q;
  assign bus.err_stuck = err_q;

endmodule

// File: tb/tb_coin_conditioner.sv
// Scoreboard bench for coin_conditioner: expected events (type, cycle) are queued
// as stimulus is driven and matched against every output pulse observed.
module tb_coin_conditioner;
  localparam int EV_10P = 0, EV_20P = 1, EV_50P = 2, EV_REFUND = 3, EV_REJECT = 4;
  localparam int EV_NONE = 7;

  typedef struct {
    int code;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  sb[$];

  coin_conditioner_if bus_if ();

  coin_conditioner #(.DB_CYCLES(4), .STUCK_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] outs_w;
  assign outs_w = {bus_if.reject, bus_if.refund, bus_if.coin50p, bus_if.coin20p, bus_if.coin10p};

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
    end
  endtask

  // Output monitor: each cycle with an active output consumes one scoreboard entry.
  int   mon_code;
  ev_t  mon_e;
  always @(posedge clk) begin
    #1;
    if (outs_w != 5'd0) begin
      if ($countones(outs_w) > 1) chk("onehot", $countones(outs_w), 1);
      mon_code = EV_NONE;
      for (int i = 4; i >= 0; i--) if (outs_w[i]) mon_code = i;
      if (sb.size() == 0) begin
        chk("spurious", mon_code, EV_NONE);
      end else begin
        mon_e = sb.pop_front();
        chk("event", mon_code, mon_e.code);
        chk("event_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic set_raw(input logic [3:0] lines);
    bus_if.raw_10p    = lines[0];
    bus_if.raw_20p    = lines[1];
    bus_if.raw_50p    = lines[2];
    bus_if.raw_refund = lines[3];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] lines, input int n);
    set_raw(lines);
    idle(n);
    set_raw(4'd0);
  endtask

  // Raw line driven at a negedge with cyc = c is first sampled at edge c+1;
  // a debounced pulse is visible after edge c+1+6, an IDLE reject after c+1+2.
  task automatic expect_ev(input int code, input int delay);
    sb.push_back('{code: code, cyc: cyc + delay});
  endtask

  int p;

  initial begin
    set_raw(4'd0);
    bus_if.busy = 1'b0;
    rst = 1'b1;
    idle(3);
    chk("rst_outs", int'(outs_w), 0);
    chk("rst_err", int'(bus_if.err_stuck), 0);
    rst = 1'b0;
    idle(10);

    // 1: clean 50p
    expect_ev(EV_50P, 7);
    hold(4'b0100, 8);
    idle(12);

    // 2: bounce on 20p; only the second segment counts
    hold(4'b0010, 2);
    idle(1);
    expect_ev(EV_20P, 7);
    hold(4'b0010, 6);
    idle(12);

    // 3: simultaneous 10p + 20p, then confirm return to IDLE with a clean 10p
    expect_ev(EV_REJECT, 3);
    hold(4'b0011, 6);
    idle(6);
    expect_ev(EV_10P, 7);
    hold(4'b0001, 6);
    idle(12);

    // 4: busy -> coin rejected, refund dropped; then a normal refund
    bus_if.busy = 1'b1;
    expect_ev(EV_REJECT, 7);
    hold(4'b0001, 8);
    idle(12);
    hold(4'b1000, 8);
    idle(12);
    bus_if.busy = 1'b0;
    expect_ev(EV_REFUND, 7);
    hold(4'b1000, 6);
    idle(12);

    // 5: stuck 50p
    p = cyc + 7;
    expect_ev(EV_50P, 7);
    set_raw(4'b0100);
    while (cyc < p + 60) @(negedge clk);
    chk("stuck_early", int'(bus_if.err_stuck), 0);
    while (cyc < p + 70) @(negedge clk);
    chk("stuck_set", int'(bus_if.err_stuck), 1);
    hold(4'b0001, 8);
    idle(10);
    chk("stuck_hold", int'(bus_if.err_stuck), 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("stuck_clr", int'(bus_if.err_stuck), 0);
    idle(10);

    // 6: reset during DEBOUNCE while 20p stays high, then a fresh 20p
    set_raw(4'b0010);
    idle(4);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(8);
    set_raw(4'd0);
    idle(8);
    expect_ev(EV_20P, 7);
    hold(4'b0010, 6);
    idle(12);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/coin_conditioner.md
Name: coin_conditioner

Overview:
Upstream front-end for the vending FSM. Takes the asynchronous, bouncy coin-sensor and refund-button lines from the mechanism and synchronises and debounces them. Each validated insertion becomes exactly one single-cycle pulse on coin10p/coin20p/coin50p/refund, which connect directly to the vending FSM inputs. The block also rejects ambiguous or ill-timed coins and flags a stuck sensor.

Parameters:
DB_CYCLES, 4, consecutive synchronised-high samples that validate a line (>=2)
STUCK_CYCLES, 64, cycles a line may stay high after acceptance before err_stuck is raised (> DB_CYCLES)
CNT_W, 7, counter width; must hold STUCK_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
raw_10p  in  1  10p sensor, asynchronous, bouncy
raw_20p  in  1  20p sensor, asynchronous, bouncy
raw_50p  in  1  50p sensor, asynchronous, bouncy
raw_refund  in  1  refund button, asynchronous, bouncy
busy  in  1  vending FSM is vending or returning change (OR of vend/ret10p/ret20p/ret20p2)
coin10p  out  1  one-cycle pulse, validated 10p
coin20p  out  1  one-cycle pulse, validated 20p
coin50p  out  1  one-cycle pulse, validated 50p
refund  out  1  one-cycle pulse, validated refund press
reject  out  1  one-cycle pulse, steer coin to reject chute
err_stuck  out  1  sticky stuck-sensor flag

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high. All outputs are registered.
- Reset: all outputs are 0, sync flops are 0, counter is 0, and the FSM enters WAIT_RELEASE. A line held high across reset is therefore never counted.
- Synchroniser: each raw line passes through a 2-flop synchroniser. The FSM sees only the synchronised value s[3:0] = {refund, 50p, 20p, 10p}.
- FSM states: IDLE, DEBOUNCE, PULSE, WAIT_RELEASE, STUCK.
- IDLE:
  - s == 0: stay.
  - Exactly one bit set: latch it as sel, set cnt=1, go to DEBOUNCE.
  - Two or more bits set: pulse reject if any coin bit is set, then go to WAIT_RELEASE.
- DEBOUNCE:
  - s == sel and cnt < DB_CYCLES: cnt++.
  - s == sel and cnt == DB_CYCLES: if busy, go to WAIT_RELEASE; pulse reject if sel is a coin (a refund is dropped silently). Otherwise go to PULSE.
  - s != sel (bounce drop, or a second line rising): return to IDLE with no output.
- PULSE: assert the output selected by sel for exactly one cycle, then go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Counter restarts on entry.
  - s != 0: cnt++. When cnt reaches STUCK_CYCLES, set err_stuck=1 and go to STUCK.
  - s == 0: counter tracks consecutive low samples. After DB_CYCLES consecutive lows, go to IDLE.
  - Any high sample resets the low count.
- STUCK: all pulse outputs and reject are suppressed. Leave only via rst. err_stuck holds until rst.
- Latency: let edge k be the first rising edge that samples a raw line high.
  - The raw line must be high on DB_CYCLES+1 consecutive edges to be accepted.
  - The output pulse is high in the cycle after edge k+DB_CYCLES+2 (DB_CYCLES=4 gives 6 cycles).
- One-hot guarantee: coin10p, coin20p, coin50p, refund and reject are mutually exclusive in every cycle. Each is at most 1 cycle wide.
- Back-to-back: the minimum spacing between accepted events is DB_CYCLES low cycles plus the debounce time. A coin held high yields one pulse only.
- busy: sampled only at DEBOUNCE completion. busy asserting after PULSE has no effect on the emitted pulse.

Test Plan:
Assume DB_CYCLES=4, STUCK_CYCLES=64, 10 ns clock.
1. Clean 50p: raw_50p high 80 ns after reset -> exactly one coin50p pulse, 1 cycle wide, in the cycle after the 6th sampling edge. reject=0.
2. Bounce: raw_20p high 20 ns, low 10 ns, high 60 ns -> exactly one coin20p pulse, timed from the second rising segment. No pulse from the first segment.
3. Simultaneous coins: raw_10p and raw_20p rise on the same edge and are held 60 ns -> one reject pulse, no coin pulses, return to IDLE after 4 low cycles.
4. Busy: busy=1 while raw_10p is held 80 ns -> one reject pulse, coin10p=0. Repeat with raw_refund -> no refund and no reject.
5. Stuck: raw_50p held 1 µs -> one coin50p pulse. err_stuck=1 after 64 further high cycles. Further raw_10p activity produces no outputs until rst. rst clears err_stuck.
6. Reset mid-insertion: raw_20p high, rst asserted during DEBOUNCE while raw_20p stays high -> no coin20p before or after reset. After release and a 4-cycle low, a fresh 20p gives one pulse.
